// File: rtl/sig_capture.sv
// Triggered sample capture buffer: records DEPTH samples around a rising-edge
// threshold crossing, with a programmable number of pre-trigger samples.
`timescale 1ns/1ps
module sig_capture #(
    parameter int unsigned A_WIDTH = 8,
    parameter int unsigned D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [D_WIDTH-1:0] din,
    input  logic               arm,
    input  logic [D_WIDTH-1:0] trig_level,
    input  logic [A_WIDTH-1:0] pretrig,
    input  logic               rd_en,
    input  logic [A_WIDTH-1:0] rd_addr,
    output logic [D_WIDTH-1:0] dout,
    output logic               busy,
    output logic               done,
    output logic [A_WIDTH-1:0] trig_addr
);

    localparam int unsigned DEPTH = 1 << A_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [D_WIDTH-1:0] r_mem [DEPTH];
    logic [A_WIDTH-1:0] r_wr_ptr;
    logic [A_WIDTH-1:0] r_cnt;
    logic [A_WIDTH-1:0] r_pretrig_q;
    logic [D_WIDTH-1:0] r_prev;
    logic               r_prev_valid;
    logic [A_WIDTH-1:0] r_trig_addr;
    logic [D_WIDTH-1:0] r_dout;

    logic               w_capturing;
    logic               w_wr;
    logic               w_arm_ok;
    logic               w_trig;
    logic [A_WIDTH-1:0] w_cnt_inc;
    logic [A_WIDTH-1:0] w_cnt_dec;
    logic [A_WIDTH-1:0] w_post_len;
    logic [A_WIDTH-1:0] w_rd_phys;

    assign w_capturing = (r_state == S_PRE) || (r_state == S_ARMED) || (r_state == S_POST);
    assign w_wr        = en && w_capturing;
    assign w_arm_ok    = arm && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_trig      = (r_state == S_ARMED) && en && r_prev_valid &&
                         (r_prev < trig_level) && (din >= trig_level);
    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_cnt_dec   = r_cnt - 1'b1;
    // DEPTH-1-pretrig_q is the bitwise inverse in A_WIDTH bits
    assign w_post_len  = ~r_pretrig_q;
    assign w_rd_phys   = r_trig_addr - r_pretrig_q + rd_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    w_next = (pretrig != '0) ? S_PRE : S_ARMED;
                end
            end
            S_PRE: begin
                if (en && (w_cnt_inc == r_pretrig_q)) begin
                    w_next = S_ARMED;
                end
            end
            S_ARMED: begin
                if (w_trig) begin
                    w_next = (w_post_len == '0) ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                if (en && (w_cnt_dec == '0)) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = w_capturing;
        done = (r_state == S_DONE);
    end

    // r_cnt counts up through PRE, then is reloaded on the trigger as the POST countdown
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr     <= '0;
            r_cnt        <= '0;
            r_pretrig_q  <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_trig_addr  <= '0;
        end else if (w_arm_ok) begin
            r_pretrig_q  <= pretrig;
            r_wr_ptr     <= '0;
            r_cnt        <= '0;
            r_prev_valid <= 1'b0;
        end else if (w_wr) begin
            r_wr_ptr     <= r_wr_ptr + 1'b1;
            r_prev       <= din;
            r_prev_valid <= 1'b1;
            case (r_state)
                S_PRE:   r_cnt <= w_cnt_inc;
                S_ARMED: begin
                    if (w_trig) begin
                        r_trig_addr <= r_wr_ptr;
                        r_cnt       <= w_post_len;
                    end
                end
                S_POST:  r_cnt <= w_cnt_dec;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout <= '0;
        end else if (rd_en) begin
            r_dout <= r_mem[w_rd_phys];
        end
    end

    assign dout      = r_dout;
    assign trig_addr = r_trig_addr;

endmodule

// File: tb/tb_sig_capture.sv
// Self-checking bench for sig_capture: randomized captures checked against a
// sample-history model of where the trigger lands and what the buffer holds.
`timescale 1ns/1ps
module tb_sig_capture;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] din;
    logic       arm;
    logic [7:0] trig_level;
    logic [3:0] pretrig;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [7:0] dout;
    logic       busy;
    logic       done;
    logic [3:0] trig_addr;

    int errors = 0;
    int checks = 0;

    logic [7:0] samp [256];
    logic [7:0] rdbuf [DEPTH];
    int         last_t;
    int         last_pt;

    always #5 clk = ~clk;

    sig_capture #(.A_WIDTH(4), .D_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .arm(arm),
        .trig_level(trig_level), .pretrig(pretrig), .rd_en(rd_en),
        .rd_addr(rd_addr), .dout(dout), .busy(busy), .done(done),
        .trig_addr(trig_addr)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Index of the first accepted sample that fires the trigger, from the
    // rules: must be in the ARMED phase (index >= pretrig), have a previous
    // sample since arm, and cross the level upward.
    function automatic int find_trig(int pt, int lvl, int n);
        for (int i = (pt > 1) ? pt : 1; i < n; i++) begin
            if (int'(samp[i-1]) < lvl && int'(samp[i]) >= lvl) return i;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(int pt, int lvl);
        pretrig    = pt[3:0];
        trig_level = lvl[7:0];
        en         = 1'b0;
        arm        = 1'b1;
        step();
        arm        = 1'b0;
    endtask

    task automatic feed(int first, int n, output int done_at, output int busy_bad);
        done_at  = -1;
        busy_bad = 0;
        for (int i = first; i < first + n; i++) begin
            en  = 1'b1;
            din = samp[i];
            step();
            if (done === 1'b1) begin
                done_at = i;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
        end
        en = 1'b0;
    endtask

    task automatic read_all();
        for (int k = 0; k < DEPTH; k++) begin
            rd_addr = k[3:0];
            rd_en   = 1'b1;
            step();
            rdbuf[k] = dout;
        end
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; arm = 1'b0; rd_en = 1'b0; din = '0;
        pretrig = '0; trig_level = '0; rd_addr = '0;
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (dout !== 8'd0) begin errors++; $display("FAIL reset_dout: got %0d expected 0", dout); end
        checks++; if (trig_addr !== 4'd0) begin errors++; $display("FAIL reset_trig_addr: got %0d expected 0", trig_addr); end
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_ramp();
        int t, da, bb;
        for (int i = 0; i < 256; i++) samp[i] = 8'(i);
        do_arm(4, 10);
        feed(0, 60, da, bb);
        t = find_trig(4, 10, 60);
        checks++; if (trig_addr !== 4'(t)) begin errors++; $display("FAIL ramp_trig_addr: got %0d expected %0d", trig_addr, t % DEPTH); end
        checks++; if (da !== t + DEPTH - 1 - 4) begin errors++; $display("FAIL ramp_done_at: got %0d expected %0d", da, t + DEPTH - 5); end
        checks++; if (bb !== 0) begin errors++; $display("FAIL ramp_busy: got %0d non-busy cycles expected 0", bb); end
        read_all();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ramp_busy_done: got %b expected 0", busy); end
        for (int k = 0; k < DEPTH; k++) begin
            checks++;
            if (rdbuf[k] !== samp[t - 4 + k]) begin errors++; $display("FAIL ramp_read[%0d]: got %0d expected %0d", k, rdbuf[k], samp[t - 4 + k]); end
        end
    endtask

    task automatic test_crossing();
        int t, da, bb;
        for (int i = 0; i < 256; i++) samp[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 5; i++) samp[i] = 8'd200;
        samp[5] = 8'd50;
        samp[6] = 8'd150;
        do_arm(0, 100);
        feed(0, 60, da, bb);
        t = find_trig(0, 100, 60);
        checks++; if (trig_addr !== 4'(t)) begin errors++; $display("FAIL cross_trig_addr: got %0d expected %0d", trig_addr, t % DEPTH); end
        checks++; if (da !== t + DEPTH - 1) begin errors++; $display("FAIL cross_done_at: got %0d expected %0d", da, t + DEPTH - 1); end
        read_all();
        for (int k = 0; k < DEPTH; k++) begin
            checks++;
            if (rdbuf[k] !== samp[t + k]) begin errors++; $display("FAIL cross_read[%0d]: got %0d expected %0d", k, rdbuf[k], samp[t + k]); end
        end
    endtask

    task automatic test_max_pretrig();
        int t, da, bb;
        for (int i = 0; i < 256; i++) samp[i] = 8'($urandom_range(0, 255));
        samp[30] = 8'd0;
        samp[31] = 8'd200;
        do_arm(15, 128);
        feed(0, 80, da, bb);
        t = find_trig(15, 128, 80);
        checks++; if (da !== t) begin errors++; $display("FAIL maxpre_done_at: got %0d expected %0d", da, t); end
        checks++; if (trig_addr !== 4'(t)) begin errors++; $display("FAIL maxpre_trig_addr: got %0d expected %0d", trig_addr, t % DEPTH); end
        rd_addr = 4'd15; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++; if (dout !== samp[t]) begin errors++; $display("FAIL maxpre_trig_sample: got %0d expected %0d", dout, samp[t]); end
        read_all();
        for (int k = 0; k < DEPTH; k++) begin
            checks++;
            if (rdbuf[k] !== samp[t - 15 + k]) begin errors++; $display("FAIL maxpre_read[%0d]: got %0d expected %0d", k, rdbuf[k], samp[t - 15 + k]); end
        end
    endtask

    task automatic test_stall_arm();
        int t, da, bb, stall_bad;
        for (int i = 0; i < 256; i++) samp[i] = 8'($urandom_range(0, 199));
        samp[10] = 8'd10;
        samp[11] = 8'd255;
        do_arm(3, 250);
        feed(0, 6, da, bb);
        checks++; if (da !== -1 || bb !== 0) begin errors++; $display("FAIL stall_pre_state: got done_at=%0d nonbusy=%0d expected -1 and 0", da, bb); end
        // stalled cycles present a crossing value and a re-arm that must both be ignored
        stall_bad = 0;
        din = 8'd255;
        for (int c = 0; c < 3; c++) begin
            en = 1'b0;
            if (c == 1) begin arm = 1'b1; pretrig = 4'd9; end
            step();
            arm = 1'b0;
            if (busy !== 1'b1 || done !== 1'b0) stall_bad++;
        end
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_state: got %0d bad cycles expected 0", stall_bad); end
        feed(6, 60, da, bb);
        t = find_trig(3, 250, 66);
        checks++; if (trig_addr !== 4'(t)) begin errors++; $display("FAIL stall_trig_addr: got %0d expected %0d", trig_addr, t % DEPTH); end
        checks++; if (da !== t + DEPTH - 1 - 3) begin errors++; $display("FAIL stall_done_at: got %0d expected %0d", da, t + DEPTH - 4); end
        read_all();
        for (int k = 0; k < DEPTH; k++) begin
            checks++;
            if (rdbuf[k] !== samp[t - 3 + k]) begin errors++; $display("FAIL stall_read[%0d]: got %0d expected %0d", k, rdbuf[k], samp[t - 3 + k]); end
        end
    endtask

    task automatic test_reset_mid_post();
        int t, da, bb, idle_bad;
        for (int i = 0; i < 256; i++) samp[i] = 8'($urandom_range(0, 99));
        samp[4] = 8'd10;
        samp[5] = 8'd150;
        do_arm(2, 100);
        feed(0, 8, da, bb);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstpost_in_post: got busy=%b expected 1", busy); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstpost_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstpost_done: got %b expected 0", done); end
        checks++; if (dout !== 8'd0) begin errors++; $display("FAIL rstpost_dout: got %0d expected 0", dout); end
        checks++; if (trig_addr !== 4'd0) begin errors++; $display("FAIL rstpost_trig_addr: got %0d expected 0", trig_addr); end
        step();
        rst = 1'b1;
        idle_bad = 0;
        for (int c = 0; c < 3; c++) begin
            en = 1'b1; din = 8'd200;
            step();
            if (busy !== 1'b0 || done !== 1'b0) idle_bad++;
        end
        en = 1'b0;
        checks++; if (idle_bad !== 0) begin errors++; $display("FAIL rstpost_wait_arm: got %0d active cycles expected 0", idle_bad); end
        for (int i = 0; i < 256; i++) samp[i] = 8'($urandom_range(0, 255));
        samp[20] = 8'd0;
        samp[21] = 8'd255;
        do_arm(5, 60);
        feed(0, 80, da, bb);
        t = find_trig(5, 60, 80);
        checks++; if (trig_addr !== 4'(t)) begin errors++; $display("FAIL rstpost_new_trig_addr: got %0d expected %0d", trig_addr, t % DEPTH); end
        checks++; if (da !== t + DEPTH - 1 - 5) begin errors++; $display("FAIL rstpost_new_done_at: got %0d expected %0d", da, t + DEPTH - 6); end
        read_all();
        for (int k = 0; k < DEPTH; k++) begin
            checks++;
            if (rdbuf[k] !== samp[t - 5 + k]) begin errors++; $display("FAIL rstpost_read[%0d]: got %0d expected %0d", k, rdbuf[k], samp[t - 5 + k]); end
        end
        last_t  = t;
        last_pt = 5;
    endtask

    task automatic test_read_hold();
        logic [7:0] exp_v;
        exp_v   = samp[last_t - last_pt + 3];
        rd_addr = 4'd3; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++; if (dout !== exp_v) begin errors++; $display("FAIL hold_read: got %0d expected %0d", dout, exp_v); end
        for (int c = 0; c < 3; c++) begin
            rd_addr = 4'(c + 7);
            step();
            checks++; if (dout !== exp_v) begin errors++; $display("FAIL hold_cycle%0d: got %0d expected %0d", c, dout, exp_v); end
        end
    endtask

    task automatic test_random();
        int t, da, bb, pt, lvl, p;
        for (int it = 0; it < 8; it++) begin
            pt  = $urandom_range(0, 15);
            lvl = $urandom_range(1, 255);
            for (int i = 0; i < 256; i++) samp[i] = 8'($urandom_range(0, 255));
            p = $urandom_range(pt + 1, pt + 60);
            samp[p-1] = 8'($urandom_range(0, lvl - 1));
            samp[p]   = 8'($urandom_range(lvl, 255));
            do_arm(pt, lvl);
            feed(0, 120, da, bb);
            t = find_trig(pt, lvl, 120);
            checks++; if (trig_addr !== 4'(t)) begin errors++; $display("FAIL rand%0d_trig_addr: got %0d expected %0d", it, trig_addr, t % DEPTH); end
            checks++; if (da !== t + DEPTH - 1 - pt) begin errors++; $display("FAIL rand%0d_done_at: got %0d expected %0d", it, da, t + DEPTH - 1 - pt); end
            checks++; if (bb !== 0) begin errors++; $display("FAIL rand%0d_busy: got %0d non-busy cycles expected 0", it, bb); end
            read_all();
            for (int k = 0; k < DEPTH; k++) begin
                checks++;
                if (rdbuf[k] !== samp[t - pt + k]) begin errors++; $display("FAIL rand%0d_read[%0d]: got %0d expected %0d", it, k, rdbuf[k], samp[t - pt + k]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_crossing();
        test_max_pretrig();
        test_stall_arm();
        test_reset_mid_post();
        test_read_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sig_capture.md
SIG_CAPTURE -- requirements
Module: sig_capture

Interface
REQ-001 The module SHALL have parameter A_WIDTH, default 8, giving a buffer address width and depth DEPTH = 2^A_WIDTH.
REQ-002 The module SHALL have parameter D_WIDTH, default 8, giving the sample width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset: low forces reset state immediately, release is synchronous to clk.
REQ-005 en  input  1  sample strobe; din is taken on each clock edge where en=1.
REQ-006 din  input  D_WIDTH  unsigned incoming sample, e.g. sinegen dout.
REQ-007 arm  input  1  single-cycle request to start a capture.
REQ-008 trig_level  input  D_WIDTH  unsigned rising-edge trigger threshold.
REQ-009 pretrig  input  A_WIDTH  number of samples to keep before the trigger sample, sampled on arm.
REQ-010 rd_en  input  1  read strobe.
REQ-011 rd_addr  input  A_WIDTH  read index relative to the oldest captured sample.
REQ-012 dout  output  D_WIDTH  registered read data.
REQ-013 busy  output  1  high in PRE, ARMED and POST.
REQ-014 done  output  1  high in DONE.
REQ-015 trig_addr  output  A_WIDTH  physical buffer address of the trigger sample.

Function
REQ-016 The state machine SHALL have states IDLE, PRE, ARMED, POST and DONE, and SHALL change state only on a clk edge.
REQ-017 On arm=1 in IDLE or DONE, the module SHALL latch pretrig into pretrig_q, clear wr_ptr, clear the sample counter and clear prev_valid.
REQ-018 On that arm, the next state SHALL be PRE when pretrig≠0, else ARMED.
REQ-019 arm in PRE, ARMED or POST SHALL be ignored.
REQ-020 In PRE, ARMED and POST, each en=1 edge SHALL write din to mem[wr_ptr], then set wr_ptr = wr_ptr+1 mod DEPTH, prev = din and prev_valid = 1.
REQ-021 en=0 SHALL advance nothing: no write, no counter, no state change.
REQ-022 PRE SHALL count accepted samples and go to ARMED on the edge that accepts sample number pretrig_q.
REQ-023 In ARMED, the trigger SHALL fire on an en=1 edge when prev_valid=1, prev < trig_level and din >= trig_level, all compared unsigned.
REQ-024 The trigger sample SHALL be written normally, and trig_addr SHALL take that sample's wr_ptr.
REQ-025 On the trigger edge, the post counter SHALL load DEPTH-1-pretrig_q; the next state SHALL be DONE if that value is 0, else POST.
REQ-026 In ARMED the buffer SHALL wrap freely, so the pretrig_q samples before the trigger are always the most recent ones.
REQ-027 POST SHALL decrement the post counter on each accepted sample and go to DONE on the edge that takes it to 0, giving exactly DEPTH samples in total.
REQ-028 In DONE, no writes SHALL occur, and the buffer and trig_addr SHALL hold until the next arm.
REQ-029 Reads SHALL have a physical address of (trig_addr - pretrig_q + rd_addr) mod DEPTH.
REQ-030 On an rd_en=1 edge dout SHALL load mem[physical], giving a latency of 1 cycle; with rd_en=0, dout SHALL hold.
REQ-031 A read and a write to the same address on the same edge SHALL return the old data (read-before-write).
REQ-032 Reads SHALL be allowed in any state; data is defined only in DONE.
REQ-033 All address arithmetic SHALL be modulo DEPTH with no overflow flag.

Reset
REQ-034 While rst=0, the module SHALL hold state=IDLE, wr_ptr=0, counters=0, prev=0, prev_valid=0, trig_addr=0, dout=0, busy=0 and done=0.
REQ-035 Reset SHALL not clear buffer contents.
REQ-036 Reset asserted mid-capture SHALL abort the capture, and after release the module SHALL wait for arm.

Verification (A_WIDTH=4, D_WIDTH=8, en=1 unless stated)
REQ-037 Ramp test: pretrig=4, trig_level=10, arm, then din=0,1,2,… one per cycle -> trigger on din=10 with trig_addr=10; done=1 the cycle after din=21 is taken; rd_addr 0..15 reads 6..21, each one cycle after rd_en.
REQ-038 Crossing test: pretrig=0, trig_level=100, din=200 held for 5 samples -> no trigger; then din=50 then 150 -> trigger on 150.
REQ-039 Maximum pretrig: pretrig=15 -> DONE directly from the trigger edge, with rd_addr=15 reading the trigger sample.
REQ-040 Stall and arm-ignore: en low for 3 cycles in ARMED, plus arm pulsed in ARMED -> wr_ptr, state and the pretrig_q latched at the original arm unchanged.
REQ-041 Reset mid-POST: rst low -> busy=0, done=0, dout=0 and trig_addr=0 immediately (asynchronously); a new arm then captures correctly.
REQ-042 Read hold: rd_en=1 with rd_addr=3 for one cycle, then rd_en=0 while rd_addr changes -> dout keeps the rd_addr=3 data.
